// File: rtl/mom_signal_gen.sv
// mom_signal_gen: turns a momentum-energy stream into ENTER/EXIT orders using hysteresis, confirmation and cooldown.
// Latency: an order is visible one cycle after its triggering sample (registered on the sampling edge).
// Backpressure: single-entry order register; an emission that finds it full and not draining is dropped and counted.
// Optional feature macro: MOM_SIG_KILL_EN adds a 'kill' input that forces EXIT from ACTIVE and FLAT from ARMING.
module mom_signal_gen #(
    parameter int DATA_W    = 16,
    parameter int HI_THRESH = 400,
    parameter int LO_THRESH = 100,
    parameter int CONFIRM   = 2,
    parameter int COOLDOWN  = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MOM_SIG_KILL_EN
    input  logic              kill,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              order_ready,
    output logic              order_valid,
    output logic              order_type,
    output logic [DATA_W-1:0] order_level,
    output logic [1:0]        state,
    output logic [7:0]        drop_cnt
);

    localparam int CNT_W = $clog2(CONFIRM + 1);
    localparam int TMR_W = $clog2(COOLDOWN + 1);

    localparam logic [DATA_W-1:0] HI_C       = DATA_W'(HI_THRESH);
    localparam logic [DATA_W-1:0] LO_C       = DATA_W'(LO_THRESH);
    localparam logic [CNT_W-1:0]  CONFIRM_C  = CNT_W'(CONFIRM);
    localparam logic [TMR_W-1:0]  COOLDOWN_C = TMR_W'(COOLDOWN);

    // Parameter sanity: hysteresis band must be non-empty and the filters non-degenerate.
    if (LO_THRESH >= HI_THRESH) begin : g_bad_thresh
        $error("mom_signal_gen: LO_THRESH must be below HI_THRESH");
    end
    if (CONFIRM < 1) begin : g_bad_confirm
        $error("mom_signal_gen: CONFIRM must be at least 1");
    end
    if (COOLDOWN < 1) begin : g_bad_cooldown
        $error("mom_signal_gen: COOLDOWN must be at least 1");
    end

    typedef enum logic [1:0] {
        FLAT   = 2'd0,
        ARMING = 2'd1,
        ACTIVE = 2'd2,
        COOL   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               order_valid_q;
    logic               order_type_q;
    logic [DATA_W-1:0]  order_level_q;
    logic [7:0]         drop_q;

    logic               emit;
    logic               emit_type;
    logic               kill_act;
    logic               is_hi;
    logic               is_lo;
    logic [CNT_W-1:0]   cnt_inc;

    assign is_hi   = (in_data >= HI_C);
    assign is_lo   = (in_data <= LO_C);
    assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef MOM_SIG_KILL_EN
    assign kill_act = kill;
`else
    assign kill_act = 1'b0;
`endif

    // Next-state, counters and order emission decision for the signal FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        emit      = 1'b0;
        emit_type = 1'b0;
        unique case (state_q)
            FLAT: begin
                if (kill_act) begin
                    cnt_d = '0;
                end else if (in_valid && is_hi) begin
                    if (CONFIRM == 1) begin
                        emit      = 1'b1;
                        emit_type = 1'b1;
                        state_d   = ACTIVE;
                        cnt_d     = '0;
                    end else begin
                        state_d = ARMING;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ARMING: begin
                if (kill_act) begin
                    state_d = FLAT;
                    cnt_d   = '0;
                end else if (in_valid) begin
                    if (is_hi) begin
                        if (cnt_inc == CONFIRM_C) begin
                            emit      = 1'b1;
                            emit_type = 1'b1;
                            state_d   = ACTIVE;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = FLAT;
                        cnt_d   = '0;
                    end
                end
            end
            ACTIVE: begin
                // Kill exits unconditionally, using whatever is on in_data as the level.
                if (kill_act || (in_valid && is_lo)) begin
                    emit      = 1'b1;
                    emit_type = 1'b0;
                    state_d   = COOL;
                    timer_d   = COOLDOWN_C;
                end
            end
            COOL: begin
                // Timer runs every clock; inputs (including kill) are ignored here.
                timer_d = timer_q - TMR_W'(1);
                if (timer_q <= TMR_W'(1)) begin
                    timer_d = '0;
                    state_d = FLAT;
                end
            end
            default: begin
                state_d = FLAT;
            end
        endcase
    end

    // FSM state, confirmation counter and cooldown timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FLAT;
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    // Single-entry order register: load when empty or draining, otherwise drop and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            order_valid_q <= 1'b0;
            order_type_q  <= 1'b0;
            order_level_q <= '0;
            drop_q        <= '0;
        end else if (emit) begin
            if (!order_valid_q || order_ready) begin
                order_valid_q <= 1'b1;
                order_type_q  <= emit_type;
                order_level_q <= in_data;
            end else if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end else if (order_valid_q && order_ready) begin
            order_valid_q <= 1'b0;
        end
    end

    assign order_valid = order_valid_q;
    assign order_type  = order_type_q;
    assign order_level = order_level_q;
    assign state       = state_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_mom_signal_gen.sv
// tb_mom_signal_gen: directed self-checking bench for mom_signal_gen with default parameters.
// Inputs are driven 1 time unit after each rising edge; outputs are checked at that same point.
// Each scenario task compares observed outputs against hand-computed values.
module tb_mom_signal_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        order_ready;
    logic        order_valid;
    logic        order_type;
    logic [15:0] order_level;
    logic [1:0]  state;
    logic [7:0]  drop_cnt;
`ifdef MOM_SIG_KILL_EN
    logic        kill;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mom_signal_gen dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MOM_SIG_KILL_EN
        .kill        (kill),
`endif
        .in_valid    (in_valid),
        .in_data     (in_data),
        .order_ready (order_ready),
        .order_valid (order_valid),
        .order_type  (order_type),
        .order_level (order_level),
        .state       (state),
        .drop_cnt    (drop_cnt)
    );

    // Present one sample, let one rising edge sample it, then settle.
    task automatic cyc(input logic v, input logic [15:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(1'b0, 16'd0);
        rst = 1'b0;
        nvec++; if (state !== 2'd0) begin $display("FAIL reset_state got=%0d exp=0", state); nerr++; end
        nvec++; if (order_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", order_valid); nerr++; end
        nvec++; if (order_type !== 1'b0) begin $display("FAIL reset_type got=%b exp=0", order_type); nerr++; end
        nvec++; if (order_level !== 16'd0) begin $display("FAIL reset_level got=%0d exp=0", order_level); nerr++; end
        nvec++; if (drop_cnt !== 8'd0) begin $display("FAIL reset_drop got=%0d exp=0", drop_cnt); nerr++; end
    endtask

    task automatic test_enter();
        order_ready = 1'b1;
        cyc(1'b1, 16'd500);
        nvec++; if (state !== 2'd1) begin $display("FAIL enter_arm_state got=%0d exp=1", state); nerr++; end
        nvec++; if (order_valid !== 1'b0) begin $display("FAIL enter_arm_valid got=%b exp=0", order_valid); nerr++; end
        cyc(1'b1, 16'd500);
        nvec++; if (order_valid !== 1'b1 || order_type !== 1'b1 || order_level !== 16'd500)
            begin $display("FAIL enter_order got=%b/%b/%0d exp=1/1/500", order_valid, order_type, order_level); nerr++; end
        nvec++; if (state !== 2'd2) begin $display("FAIL enter_state got=%0d exp=2", state); nerr++; end
        cyc(1'b0, 16'd0);
        nvec++; if (order_valid !== 1'b0) begin $display("FAIL enter_drain got=%b exp=0", order_valid); nerr++; end
        // Leave via EXIT and full cooldown so the next scenario starts in FLAT.
        cyc(1'b1, 16'd50);
        nvec++; if (order_valid !== 1'b1 || order_type !== 1'b0 || order_level !== 16'd50)
            begin $display("FAIL exit50_order got=%b/%b/%0d exp=1/0/50", order_valid, order_type, order_level); nerr++; end
        for (int i = 0; i < 7; i++) cyc(1'b0, 16'd0);
        nvec++; if (state !== 2'd3) begin $display("FAIL cool7_state got=%0d exp=3", state); nerr++; end
        cyc(1'b0, 16'd0);
        nvec++; if (state !== 2'd0) begin $display("FAIL cool8_state got=%0d exp=0", state); nerr++; end
    endtask

    task automatic test_confirm();
        cyc(1'b1, 16'd500);
        cyc(1'b1, 16'd300);
        nvec++; if (state !== 2'd0 || order_valid !== 1'b0)
            begin $display("FAIL abort_arm got=%0d/%b exp=0/0", state, order_valid); nerr++; end
        cyc(1'b1, 16'd500);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'd0);
        nvec++; if (state !== 2'd1) begin $display("FAIL gap_state got=%0d exp=1", state); nerr++; end
        cyc(1'b1, 16'd450);
        nvec++; if (order_valid !== 1'b1 || order_type !== 1'b1 || order_level !== 16'd450)
            begin $display("FAIL gap_enter got=%b/%b/%0d exp=1/1/450", order_valid, order_type, order_level); nerr++; end
        nvec++; if (state !== 2'd2) begin $display("FAIL gap_state2 got=%0d exp=2", state); nerr++; end
    endtask

    task automatic test_exit_cool();
        cyc(1'b1, 16'd101);
        nvec++; if (order_valid !== 1'b0 || state !== 2'd2)
            begin $display("FAIL hyst101 got=%b/%0d exp=0/2", order_valid, state); nerr++; end
        cyc(1'b1, 16'd100);
        nvec++; if (order_valid !== 1'b1 || order_type !== 1'b0 || order_level !== 16'd100)
            begin $display("FAIL exit100 got=%b/%b/%0d exp=1/0/100", order_valid, order_type, order_level); nerr++; end
        nvec++; if (state !== 2'd3) begin $display("FAIL exit100_state got=%0d exp=3", state); nerr++; end
        for (int i = 0; i < 7; i++) cyc(1'b1, 16'd900);
        nvec++; if (state !== 2'd3 || order_valid !== 1'b0)
            begin $display("FAIL cool_ignore got=%0d/%b exp=3/0", state, order_valid); nerr++; end
        cyc(1'b1, 16'd900);
        nvec++; if (state !== 2'd0) begin $display("FAIL cool_end got=%0d exp=0", state); nerr++; end
        cyc(1'b1, 16'd900);
        cyc(1'b1, 16'd900);
        nvec++; if (order_valid !== 1'b1 || order_type !== 1'b1 || order_level !== 16'd900)
            begin $display("FAIL reenter got=%b/%b/%0d exp=1/1/900", order_valid, order_type, order_level); nerr++; end
    endtask

    task automatic test_drop();
        cyc(1'b1, 16'd50);
        for (int i = 0; i < 8; i++) cyc(1'b0, 16'd0);
        order_ready = 1'b0;
        cyc(1'b1, 16'd500);
        cyc(1'b1, 16'd500);
        nvec++; if (order_valid !== 1'b1 || order_type !== 1'b1 || order_level !== 16'd500)
            begin $display("FAIL held_enter got=%b/%b/%0d exp=1/1/500", order_valid, order_type, order_level); nerr++; end
        cyc(1'b1, 16'd200);
        cyc(1'b1, 16'd50);
        nvec++; if (drop_cnt !== 8'd1) begin $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); nerr++; end
        nvec++; if (order_valid !== 1'b1 || order_type !== 1'b1 || order_level !== 16'd500)
            begin $display("FAIL drop_hold got=%b/%b/%0d exp=1/1/500", order_valid, order_type, order_level); nerr++; end
        nvec++; if (state !== 2'd3) begin $display("FAIL drop_state got=%0d exp=3", state); nerr++; end
        for (int i = 0; i < 8; i++) cyc(1'b0, 16'd0);
        cyc(1'b1, 16'd600);
        order_ready = 1'b1;
        cyc(1'b1, 16'd700);
        nvec++; if (order_valid !== 1'b1 || order_type !== 1'b1 || order_level !== 16'd700)
            begin $display("FAIL drain_load got=%b/%b/%0d exp=1/1/700", order_valid, order_type, order_level); nerr++; end
        nvec++; if (drop_cnt !== 8'd1) begin $display("FAIL drain_drop got=%0d exp=1", drop_cnt); nerr++; end
    endtask

    task automatic test_reset_mid();
        order_ready = 1'b0;
        cyc(1'b1, 16'd50);
        nvec++; if (drop_cnt !== 8'd2) begin $display("FAIL drop2 got=%0d exp=2", drop_cnt); nerr++; end
        for (int i = 0; i < 8; i++) cyc(1'b0, 16'd0);
        cyc(1'b1, 16'd500);
        nvec++; if (state !== 2'd1 || order_valid !== 1'b1)
            begin $display("FAIL prerst got=%0d/%b exp=1/1", state, order_valid); nerr++; end
        rst = 1'b1;
        cyc(1'b0, 16'd0);
        rst = 1'b0;
        nvec++; if (state !== 2'd0 || order_valid !== 1'b0 || drop_cnt !== 8'd0)
            begin $display("FAIL midrst got=%0d/%b/%0d exp=0/0/0", state, order_valid, drop_cnt); nerr++; end
        cyc(1'b1, 16'd500);
        nvec++; if (state !== 2'd1 || order_valid !== 1'b0)
            begin $display("FAIL postrst got=%0d/%b exp=1/0", state, order_valid); nerr++; end
    endtask

`ifdef MOM_SIG_KILL_EN
    task automatic test_kill();
        order_ready = 1'b1;
        cyc(1'b1, 16'd500);
        cyc(1'b0, 16'd0);
        nvec++; if (state !== 2'd2) begin $display("FAIL kill_pre got=%0d exp=2", state); nerr++; end
        kill = 1'b1;
        cyc(1'b0, 16'd350);
        kill = 1'b0;
        nvec++; if (order_valid !== 1'b1 || order_type !== 1'b0 || order_level !== 16'd350)
            begin $display("FAIL kill_exit got=%b/%b/%0d exp=1/0/350", order_valid, order_type, order_level); nerr++; end
        nvec++; if (state !== 2'd3) begin $display("FAIL kill_state got=%0d exp=3", state); nerr++; end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 16'd0;
        order_ready = 1'b1;
`ifdef MOM_SIG_KILL_EN
        kill        = 1'b0;
`endif
        test_reset();
        test_enter();
        test_confirm();
        test_exit_cool();
        test_drop();
        test_reset_mid();
`ifdef MOM_SIG_KILL_EN
        test_kill();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mom_signal_gen.md
Name: mom_signal_gen

Overview:
Downstream consumer of the sliding-window second-moment stage. Takes the 16-bit momentum-energy stream and turns it into discrete ENTER/EXIT trade signals. Signals are generated with threshold hysteresis, a multi-sample confirmation filter and a post-exit cooldown. Each signal is presented to the order-formatting stage through a single-entry valid/ready output register.

Parameters:
DATA_W, 16, width of the momentum metric input and of order_level
HI_THRESH, 400, entry threshold; a sample qualifies for entry when in_data >= HI_THRESH
LO_THRESH, 100, exit threshold; a sample qualifies for exit when in_data <= LO_THRESH
CONFIRM, 2, number of consecutive valid qualifying samples required before ENTER (>= 1)
COOLDOWN, 8, clock cycles spent ignoring input after an EXIT (>= 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_data carries a new metric sample this cycle
in_data  in  DATA_W  momentum metric, unsigned
order_ready  in  1  downstream accepts the order this cycle
order_valid  out  1  order register holds an unconsumed order
order_type  out  1  1 = ENTER, 0 = EXIT
order_level  out  DATA_W  in_data value of the sample that triggered the order
state  out  2  current FSM state: 0 FLAT, 1 ARMING, 2 ACTIVE, 3 COOL
drop_cnt  out  8  saturating count of orders lost to a full order register

Behaviour:
- Reset (rst=1 at clock edge): state=FLAT; confirm counter=0; cooldown timer=0; order_valid=0; order_type=0; order_level=0; drop_cnt=0. Reset mid-operation discards any pending order and any partial confirmation.
- Elaboration check: LO_THRESH < HI_THRESH, CONFIRM >= 1, COOLDOWN >= 1; otherwise $error.
- Cycles with in_valid=0 never change state or counters, except the COOL timer.
- FLAT:
  - valid sample >= HI_THRESH: if CONFIRM=1, emit ENTER and go to ACTIVE; else go to ARMING with confirm count=1.
  - Any other valid sample: stay in FLAT.
- ARMING:
  - valid sample >= HI_THRESH: increment count; when count reaches CONFIRM, emit ENTER (level = this sample), go to ACTIVE, clear count.
  - valid sample < HI_THRESH: go to FLAT, clear count.
- ACTIVE:
  - valid sample <= LO_THRESH: emit EXIT (level = sample); go to COOL; load timer=COOLDOWN.
  - Any other valid sample: stay in ACTIVE.
- COOL:
  - Timer decrements every clock regardless of in_valid; all samples are ignored.
  - The clock edge at which the timer goes 1->0 moves state to FLAT. COOL therefore lasts exactly COOLDOWN cycles.
- Emission latency: order_valid/order_type/order_level are registered on the same edge that samples the triggering input, so they are visible one cycle after the input is presented.
- Handshake: the order is consumed on any edge with order_valid & order_ready. order_valid then drops unless a new emission loads on the same edge.
  - order_type/order_level are stable while order_valid=1 and order_ready=0.
- Emission while the register is occupied and not draining this edge: new order dropped, held order unchanged, drop_cnt += 1, saturating at 255. The FSM transition still occurs.
- Emission on the same edge the held order drains: new order loaded, no drop.
- Comparisons are unsigned, full DATA_W; no arithmetic on in_data beyond compare.

Optional Feature:
MOM_SIG_KILL_EN:
- Defined: adds input port kill (1 bit, risk-manager kill switch).
  - kill=1 in ACTIVE: emit EXIT with level=in_data (regardless of in_valid/threshold) on that edge; go to COOL.
  - kill=1 in FLAT/ARMING: force FLAT, clear count, no emission.
  - kill=1 in COOL: no effect.
  - kill has priority over the normal data path in the same cycle.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
1. Reset, then valid 500, 500 back-to-back, order_ready=1 -> one cycle after second sample: order_valid=1, order_type=1, order_level=500, state=ACTIVE; order_valid drops next cycle.
2. From FLAT: 500 then 300 -> state returns to FLAT, no order. Then 500, in_valid=0 for 3 cycles, 450 -> ENTER with level 450 (gaps do not break confirmation).
3. In ACTIVE: sample 101 -> no order. Sample 100 -> EXIT level 100, state=COOL. Valid 900 on each of next 8 cycles -> ignored, state=FLAT after cycle 8. Then 900, 900 -> ENTER.
4. order_ready=0; ENTER 500; later EXIT 50 -> drop_cnt=1, held order still ENTER/500. Next: raise order_ready on the same cycle a new emission occurs -> new order loaded, drop_cnt stays 1.
5. Assert rst for one cycle while in ARMING with an undrained order pending -> next cycle state=FLAT, order_valid=0, drop_cnt=0; subsequent 500 goes only to ARMING.
6. (MOM_SIG_KILL_EN) ACTIVE, in_data=350, in_valid=0, kill=1 -> EXIT with level 350 next cycle, state=COOL.
